// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks dest/rf_enable/load for the instructions in EX, MEM and WB. It uses
// those to pick forwarding sources for the two register-file read ports and
// to stall on a load-use hazard. A saturating counter records stall cycles.
module hazard_forward_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_rf_enable,
    input  logic             id_load_instr,
    input  logic             stat_clear,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic             control_mux,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic [4:0]       ex_dest,
    output logic [4:0]       mem_dest,
    output logic [4:0]       wb_dest,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_ID  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Shadow copies of the pipeline control fields.
    logic [4:0]       r_ex_dest, r_mem_dest, r_wb_dest;
    logic             r_ex_rf, r_mem_rf, r_wb_rf;
    logic             r_ex_load, r_mem_load, r_wb_load;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_ex_live, w_mem_live, w_wb_live;
    logic             w_stall;

    // Register 0 is hard-wired zero, so a write to it never produces data worth forwarding.
    assign w_ex_live  = r_ex_rf  && (r_ex_dest  != 5'd0);
    assign w_mem_live = r_mem_rf && (r_mem_dest != 5'd0);
    assign w_wb_live  = r_wb_rf  && (r_wb_dest  != 5'd0);

    // Youngest producer wins: EX over MEM over WB, else the register file value.
    function automatic logic [1:0] pick_src(input logic [4:0] src);
        if (w_ex_live && r_ex_dest == src)
            return SEL_EX;
        else if (w_mem_live && r_mem_dest == src)
            return SEL_MEM;
        else if (w_wb_live && r_wb_dest == src)
            return SEL_WB;
        else
            return SEL_ID;
    endfunction

    // Forward selects and load-use stall detection, all zero-latency.
    always_comb begin
        fwd_rs_sel = pick_src(id_rs);
        fwd_rt_sel = pick_src(id_rt);
        w_stall    = r_ex_load && w_ex_live &&
                     ((id_uses_rs && id_rs == r_ex_dest) ||
                      (id_uses_rt && id_rt == r_ex_dest));
    end

    assign control_mux  = w_stall;
    assign pc_enable    = ~w_stall;
    assign if_id_enable = ~w_stall;

    // Advance the shadow pipeline; a stall injects a bubble into EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_dest  <= 5'd0;
            r_ex_rf    <= 1'b0;
            r_ex_load  <= 1'b0;
            r_mem_dest <= 5'd0;
            r_mem_rf   <= 1'b0;
            r_mem_load <= 1'b0;
            r_wb_dest  <= 5'd0;
            r_wb_rf    <= 1'b0;
            r_wb_load  <= 1'b0;
        end else begin
            r_wb_dest  <= r_mem_dest;
            r_wb_rf    <= r_mem_rf;
            r_wb_load  <= r_mem_load;
            r_mem_dest <= r_ex_dest;
            r_mem_rf   <= r_ex_rf;
            r_mem_load <= r_ex_load;
            if (w_stall) begin
                r_ex_dest <= 5'd0;
                r_ex_rf   <= 1'b0;
                r_ex_load <= 1'b0;
            end else begin
                r_ex_dest <= id_dest;
                r_ex_rf   <= id_rf_enable;
                r_ex_load <= id_load_instr;
            end
        end
    end

    // Stall-cycle counter: clear has priority, otherwise saturating increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_count <= '0;
        else if (stat_clear)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    assign ex_dest     = r_ex_dest;
    assign mem_dest    = r_mem_dest;
    assign wb_dest     = r_wb_dest;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: instruction-history model plus directed literal checks.
module tb_hazard_forward_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic             id_uses_rs, id_uses_rt, id_rf_enable, id_load_instr, stat_clear;
    logic [1:0]       fwd_rs_sel, fwd_rt_sel;
    logic             control_mux, pc_enable, if_id_enable;
    logic [4:0]       ex_dest, mem_dest, wb_dest;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .stat_clear(stat_clear),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .control_mux(control_mux), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[0] is the instruction issued one cycle ago (now in EX), hist[1] two ago, hist[2] three ago.
    typedef struct packed {
        logic [4:0] dest;
        logic       rf;
        logic       ld;
    } ins_t;

    ins_t hist[$];
    int   m_count;

    function automatic bit m_live(input ins_t x);
        return x.rf && x.dest != 5'd0;
    endfunction

    // Forward source: age of the youngest live writer of r (1..3), or 0 for the register file.
    function automatic int m_sel(input logic [4:0] r);
        for (int a = 0; a < 3; a++)
            if (m_live(hist[a]) && hist[a].dest == r) return a + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        return hist[0].ld && m_live(hist[0]) &&
               ((id_uses_rs && id_rs == hist[0].dest) || (id_uses_rt && id_rt == hist[0].dest));
    endfunction

    task automatic m_clear();
        hist.delete();
        repeat (3) hist.push_back(ins_t'(0));
        m_count = 0;
    endtask

    initial m_clear();

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clear();
        end else begin
            bit   st;
            ins_t issued;
            st = m_stall();
            issued = st ? ins_t'(0) : ins_t'{id_dest, id_rf_enable, id_load_instr};
            if (stat_clear)
                m_count = 0;
            else if (st && m_count < (1 << CNT_W) - 1)
                m_count = m_count + 1;
            hist.push_front(issued);
            void'(hist.pop_back());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin
        if (hist.size() == 3) begin
            bit st;
            st = m_stall();
            chk("m_fwd_rs", 32'(fwd_rs_sel), 32'(m_sel(id_rs)));
            chk("m_fwd_rt", 32'(fwd_rt_sel), 32'(m_sel(id_rt)));
            chk("m_control_mux", 32'(control_mux), 32'(st));
            chk("m_pc_enable", 32'(pc_enable), 32'(!st));
            chk("m_if_id_enable", 32'(if_id_enable), 32'(!st));
            chk("m_ex_dest", 32'(ex_dest), 32'(hist[0].dest));
            chk("m_mem_dest", 32'(mem_dest), 32'(hist[1].dest));
            chk("m_wb_dest", 32'(wb_dest), 32'(hist[2].dest));
            chk("m_stall_count", 32'(stall_count), 32'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    // Present one ID instruction for one cycle; returns at the falling edge of that cycle.
    task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] dest, input logic rf,
                         input logic ld, input logic clr);
        @(posedge clk);
        #2;
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dest; id_rf_enable = rf; id_load_instr = ld; stat_clear = clr;
        @(negedge clk);
    endtask

    task automatic nop();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_dest = '0; id_rf_enable = 0; id_load_instr = 0; stat_clear = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Build nonzero state: one completed load-use stall, then a second stall in progress.
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);   // lw r3
        apply(5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);   // uses r3 -> stall
        chk("pre_stall_ctl", 32'(control_mux), 32'd1);
        apply(5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);   // replay
        chk("pre_cnt", 32'(stall_count), 32'd1);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);   // lw r3
        apply(5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);   // stall again
        chk("pre_reset_pc", 32'(pc_enable), 32'd0);

        // Test 1: asynchronous reset mid-stall clears everything immediately.
        #1 reset = 1'b1;
        #1;
        chk("rst_fwd_rs", 32'(fwd_rs_sel), 32'd0);
        chk("rst_fwd_rt", 32'(fwd_rt_sel), 32'd0);
        chk("rst_control_mux", 32'(control_mux), 32'd0);
        chk("rst_pc_enable", 32'(pc_enable), 32'd1);
        chk("rst_if_id_enable", 32'(if_id_enable), 32'd1);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        chk("rst_dests", 32'({ex_dest, mem_dest, wb_dest}), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Test 2: forward path ages through EX, MEM, WB, then register file.
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("age_ex", 32'(fwd_rs_sel), 32'd1);
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("age_mem", 32'(fwd_rs_sel), 32'd2);
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("age_wb", 32'(fwd_rs_sel), 32'd3);
        apply(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("age_id", 32'(fwd_rs_sel), 32'd0);

        // Test 3: same dest in EX and MEM -> EX wins. Select is computed even when unused.
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("prio_ex", 32'(fwd_rt_sel), 32'd1);

        // rs == rt: both selects identical.
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        apply(5'd4, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("same_rs", 32'(fwd_rs_sel), 32'd1);
        chk("same_rt", 32'(fwd_rt_sel), 32'd1);

        // Test 4: load-use stall lasts one cycle, then forwards from MEM.
        nop();
        apply(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);   // lw r8
        apply(5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // uses r8
        chk("lu_control_mux", 32'(control_mux), 32'd1);
        chk("lu_pc_enable", 32'(pc_enable), 32'd0);
        chk("lu_if_id_enable", 32'(if_id_enable), 32'd0);
        apply(5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // replay
        chk("lu_after_ctl", 32'(control_mux), 32'd0);
        chk("lu_after_sel", 32'(fwd_rs_sel), 32'd2);
        chk("lu_after_cnt", 32'(stall_count), 32'd1);
        chk("lu_bubble_ex", 32'(ex_dest), 32'd0);

        // Test 5: writes to r0 (including a load) never forward or stall.
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("r0_rs", 32'(fwd_rs_sel), 32'd0);
        chk("r0_rt", 32'(fwd_rt_sel), 32'd0);
        chk("r0_nostall", 32'(control_mux), 32'd0);

        // Back-to-back loads: lw r10; lw r11 uses r10; user of r11.
        apply(5'd1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        apply(5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        chk("b2b_stall1", 32'(control_mux), 32'd1);
        apply(5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        apply(5'd2, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("b2b_stall2", 32'(control_mux), 32'd1);
        apply(5'd2, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("b2b_sel", 32'(fwd_rt_sel), 32'd2);

        // Test 6: counter saturates at 3 with CNT_W=2.
        for (int k = 0; k < 5; k++) begin
            apply(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
            apply(5'd0, 5'd9, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
            apply(5'd0, 5'd9, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_cnt", 32'(stall_count), 32'd3);
        apply(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        apply(5'd0, 5'd9, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);  // stall with clear
        chk("clr_stall", 32'(control_mux), 32'd1);
        apply(5'd0, 5'd9, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        chk("clr_cnt", 32'(stall_count), 32'd0);

        // Mixed traffic over a small register set, checked by the model only.
        for (int k = 0; k < 40; k++) begin
            apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'(k == 20));
        end

        nop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
